vam16_op_sequencer: RTL and testbench

- Synthesizable initiator for the VAM-16 multiplier's start/ready protocol.
- Accepts operand pairs on a valid/ready input and buffers them in a small FIFO.
- Issues each pair to the multiplier as packed bus32 plus a one-cycle startSignal, then waits for readyPulse.
- Captures rsltW and presents it on a valid/ready output; sits between a host/stream source and the multiplier top.

---
 rtl/vam16_pkg.sv | 28 ++
 rtl/vam16_op_fifo.sv | 55 +++++
 rtl/vam16_op_sequencer.sv | 129 ++++++++++++
 tb/tb_vam16_op_sequencer.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vam16_pkg.sv
// Shared types and default widths for the VAM-16 operand sequencer.
package vam16_pkg;

    localparam int OPND_W = 16;
    localparam int RSLT_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT,
        HOLD
    } state_t;

    typedef struct packed {
        logic [OPND_W-1:0] opndA;
        logic [OPND_W-1:0] opndB;
    } opnd_pair_t;

    function automatic opnd_pair_t make_pair(input logic [OPND_W-1:0] a,
                                             input logic [OPND_W-1:0] b);
        opnd_pair_t p;
        p.opndA = a;
        p.opndB = b;
        return p;
    endfunction

endpackage

// File: rtl/vam16_op_fifo.sv
// Synchronous operand-pair FIFO with a count register; DEPTH must be a power of two.
module vam16_op_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_data,
    output logic              o_full,
    output logic              o_empty
);
    import vam16_pkg::*;

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              w_push;
    logic              w_pop;

    // Full/empty come from the registered count, so a push offered while full
    // is refused even if a pop frees a slot in the same cycle.
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_data  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/vam16_op_sequencer.sv
// Start/ready initiator for the VAM-16 multiplier: FIFO-buffered operands, issue FSM, result register.
// Optional readyPulse watchdog is built when VAM_TIMEOUT_EN is defined.
module vam16_op_sequencer #(
    parameter int OPND_W  = 16,
    parameter int RSLT_W  = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [OPND_W-1:0]   in_opndA,
    input  logic [OPND_W-1:0]   in_opndB,
    output logic [2*OPND_W-1:0] bus32,
    output logic                startSignal,
    input  logic [RSLT_W-1:0]   rsltW,
    input  logic                readyPulse,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [RSLT_W-1:0]   out_rslt,
    output logic                busy,
    output logic                timeout_err
);
    import vam16_pkg::*;

    localparam int PAIR_W = 2 * OPND_W;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_rslt_take;
    logic              w_wd_expire;
    logic [PAIR_W-1:0] w_head;
    logic [PAIR_W-1:0] r_bus32;
    logic [RSLT_W-1:0] r_out_rslt;
    logic              r_out_valid;

    vam16_op_fifo #(
        .DATA_W (PAIR_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (in_valid),
        .i_data  ({in_opndA, in_opndB}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_pop       = (r_state == IDLE) && !w_empty;
    assign w_rslt_take = (r_state == WAIT) && readyPulse;

`ifdef VAM_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [WD_W-1:0] r_wd_cnt;
    logic            r_timeout_err;

    // readyPulse on the terminal cycle takes priority over the watchdog.
    assign w_wd_expire = (r_state == WAIT) && !readyPulse
                         && (r_wd_cnt == WD_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wd_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state == START)     r_wd_cnt <= '0;
            else if (r_state == WAIT) r_wd_cnt <= r_wd_cnt + 1'b1;
            if (w_wd_expire) r_timeout_err <= 1'b1;
        end
    end

    assign timeout_err = r_timeout_err;
`else
    assign w_wd_expire = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (!w_empty) w_state_nxt = LOAD;
            LOAD:    w_state_nxt = START;
            START:   w_state_nxt = WAIT;
            WAIT:    if (w_rslt_take || w_wd_expire) w_state_nxt = HOLD;
            HOLD:    if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // bus32 is loaded on the pop so it is already stable throughout LOAD.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bus32     <= '0;
            r_out_rslt  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_pop) r_bus32 <= w_head;
            if (w_rslt_take) begin
                r_out_rslt  <= rsltW;
                r_out_valid <= 1'b1;
            end else if (w_wd_expire) begin
                r_out_rslt  <= '1;
                r_out_valid <= 1'b1;
            end else if ((r_state == HOLD) && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready    = !w_full;
    assign bus32       = r_bus32;
    assign startSignal = (r_state == START) && !rst;
    assign out_valid   = r_out_valid;
    assign out_rslt    = r_out_rslt;
    assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_vam16_op_sequencer.sv
// Directed bench for vam16_op_sequencer: table-driven single ops plus FIFO, backpressure,
// spurious-pulse, reset and watchdog sequences.
module tb_vam16_op_sequencer;

`ifdef VAM_TIMEOUT_EN
    localparam int TB_TIMEOUT = 8;
`else
    localparam int TB_TIMEOUT = 64;
`endif

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_opndA;
    logic [15:0] in_opndB;
    logic [31:0] bus32;
    logic        startSignal;
    logic [31:0] rsltW;
    logic        readyPulse;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rslt;
    logic        busy;
    logic        timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    vam16_op_sequencer #(
        .OPND_W  (16),
        .RSLT_W  (32),
        .DEPTH   (4),
        .TIMEOUT (TB_TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_opndA    (in_opndA),
        .in_opndB    (in_opndB),
        .bus32       (bus32),
        .startSignal (startSignal),
        .rsltW       (rsltW),
        .readyPulse  (readyPulse),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_rslt    (out_rslt),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "time limit");
    end

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] exp_bus;
        logic [31:0] prod;
    } vec_t;

    vec_t        vecs [6];
    logic [15:0] fa [6];
    logic [15:0] fb [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_now(input logic [15:0] a, input logic [15:0] b);
        in_valid = 1'b1;
        in_opndA = a;
        in_opndB = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_start(input string name);
        int k;
        k = 0;
        while (!startSignal && k < 60) begin
            tick();
            k++;
        end
        chk({name, "_start_seen"}, startSignal, 1);
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        int bad;
        int cyc;
        logic acc;

        vecs[0] = '{16'h00F0, 16'h0186, 32'h00F0_0186, 32'h0001_6DA0};
        vecs[1] = '{16'hFFFF, 16'h0001, 32'hFFFF_0001, 32'h0000_FFFF};
        vecs[2] = '{16'h1234, 16'h0010, 32'h1234_0010, 32'h0001_2340};
        vecs[3] = '{16'h0000, 16'hABCD, 32'h0000_ABCD, 32'h0000_0000};
        vecs[4] = '{16'h8000, 16'h0002, 32'h8000_0002, 32'h0001_0000};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 32'hFFFF_FFFF, 32'hFFFE_0001};
        for (int i = 0; i < 6; i++) begin
            fa[i] = 16'h1000 + 16'(i);
            fb[i] = 16'h2000 + 16'(3 * i);
        end

        rst = 1'b1; in_valid = 1'b0; in_opndA = '0; in_opndB = '0;
        rsltW = '0; readyPulse = 1'b0; out_ready = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_bus32", bus32, 0);
        chk("rst_start", startSignal, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_rslt", out_rslt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_timeout_err", timeout_err, 0);

        // Single ops: readyPulse ten cycles after the start pulse.
        for (int v = 0; v < 6; v++) begin
            push_now(vecs[v].a, vecs[v].b);
            chk($sformatf("v%0d_idle_after_push", v), busy, 0);
            tick();
            chk($sformatf("v%0d_load_bus32", v), bus32, vecs[v].exp_bus);
            chk($sformatf("v%0d_load_nostart", v), startSignal, 0);
            tick();
            chk($sformatf("v%0d_start", v), startSignal, 1);
            chk($sformatf("v%0d_start_bus32", v), bus32, vecs[v].exp_bus);
            tick();
            chk($sformatf("v%0d_start_onecycle", v), startSignal, 0);
            repeat (9) tick();
            chk($sformatf("v%0d_no_early_valid", v), out_valid, 0);
            readyPulse = 1'b1; rsltW = vecs[v].prod;
            tick();
            readyPulse = 1'b0; rsltW = '0;
            chk($sformatf("v%0d_out_valid", v), out_valid, 1);
            chk($sformatf("v%0d_out_rslt", v), out_rslt, vecs[v].prod);
            release_out();
            chk($sformatf("v%0d_released", v), out_valid, 0);
            chk($sformatf("v%0d_back_idle", v), busy, 0);
        end

        // FIFO fill/wrap with the multiplier stalled on an earlier op.
        out_ready = 1'b1;
        push_now(16'h0AAA, 16'h0555);
        wait_start("fill_p0");
        tick();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("fill_ready_%0d", i), in_ready, 1);
            push_now(fa[i], fb[i]);
        end
        chk("fill_full_in_ready", in_ready, 0);
        in_valid = 1'b1; in_opndA = 16'hEEEE; in_opndB = 16'hEEEE;
        repeat (3) tick();
        in_valid = 1'b0;
        chk("fill_still_full", in_ready, 0);
        readyPulse = 1'b1; rsltW = 32'h0000_0AAA;
        tick();
        readyPulse = 1'b0;
        chk("fill_p0_rslt", out_rslt, 32'h0000_0AAA);
        tick();
        fork
            begin
                for (int i = 4; i < 6; i++) begin
                    in_valid = 1'b1; in_opndA = fa[i]; in_opndB = fb[i];
                    acc = 1'b0;
                    for (int k = 0; k < 100 && !acc; k++) begin
                        acc = in_ready;
                        tick();
                    end
                    chk($sformatf("late_push_%0d", i), acc, 1);
                end
                in_valid = 1'b0;
            end
            begin
                for (int j = 0; j < 6; j++) begin
                    wait_start($sformatf("drain_%0d", j));
                    chk($sformatf("drain_order_%0d", j), bus32, {fa[j], fb[j]});
                    tick();
                    readyPulse = 1'b1; rsltW = 32'h100 + 32'(j);
                    tick();
                    readyPulse = 1'b0;
                    chk($sformatf("drain_valid_%0d", j), out_valid, 1);
                    chk($sformatf("drain_rslt_%0d", j), out_rslt, 32'h100 + 32'(j));
                    tick();
                end
            end
        join
        out_ready = 1'b0;
        repeat (2) tick();
        chk("drain_idle", busy, 0);
        chk("drain_in_ready", in_ready, 1);

        // Output backpressure for 20 cycles with a second op queued.
        push_now(16'h0101, 16'h0202);
        push_now(16'h0303, 16'h0404);
        wait_start("bp");
        tick();
        readyPulse = 1'b1; rsltW = 32'hCAFE_0001;
        tick();
        readyPulse = 1'b0;
        chk("bp_valid", out_valid, 1);
        chk("bp_rslt", out_rslt, 32'hCAFE_0001);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_rslt !== 32'hCAFE_0001 || out_valid !== 1'b1 ||
                startSignal !== 1'b0 || busy !== 1'b1) bad++;
        end
        chk("bp_stall_violations", bad, 0);
        chk("bp_fifo_accepting", in_ready, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        cyc = 1;
        while (!startSignal && cyc < 10) begin
            tick();
            cyc++;
        end
        chk("bp_restart_latency", cyc, 3);
        chk("bp_second_bus32", bus32, 32'h0303_0404);
        tick();
        readyPulse = 1'b1; rsltW = 32'hCAFE_0002;
        tick();
        readyPulse = 1'b0;
        chk("bp_second_rslt", out_rslt, 32'hCAFE_0002);
        release_out();

        // Spurious readyPulse in IDLE and in START.
        readyPulse = 1'b1; rsltW = 32'hDEAD_BEEF;
        tick();
        readyPulse = 1'b0;
        chk("spur_idle_valid", out_valid, 0);
        chk("spur_idle_rslt", out_rslt, 32'hCAFE_0002);
        chk("spur_idle_busy", busy, 0);
        push_now(16'h0007, 16'h0009);
        tick();
        tick();
        chk("spur_in_start", startSignal, 1);
        readyPulse = 1'b1; rsltW = 32'hBAD0_BAD0;
        tick();
        readyPulse = 1'b0;
        chk("spur_start_valid", out_valid, 0);
        repeat (3) tick();
        chk("spur_wait_valid", out_valid, 0);
        chk("spur_wait_busy", busy, 1);
        readyPulse = 1'b1; rsltW = 32'h0000_003F;
        tick();
        readyPulse = 1'b0;
        chk("spur_real_valid", out_valid, 1);
        chk("spur_real_rslt", out_rslt, 32'h0000_003F);
        release_out();

        // Reset in the middle of WAIT with another op still queued.
        push_now(16'h1111, 16'h2222);
        push_now(16'h3333, 16'h4444);
        wait_start("rw");
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rw_in_ready", in_ready, 1);
        chk("rw_bus32", bus32, 0);
        chk("rw_start", startSignal, 0);
        chk("rw_out_valid", out_valid, 0);
        chk("rw_out_rslt", out_rslt, 0);
        chk("rw_busy", busy, 0);
        chk("rw_timeout_err", timeout_err, 0);
        repeat (3) tick();
        chk("rw_fifo_empty", busy, 0);
        readyPulse = 1'b1; rsltW = 32'h1234_5678;
        tick();
        readyPulse = 1'b0;
        chk("rw_late_pulse_valid", out_valid, 0);
        chk("rw_late_pulse_rslt", out_rslt, 0);

        // Reset asserted during START must suppress the pulse at once.
        push_now(16'h5555, 16'h6666);
        tick();
        tick();
        chk("rs_start_before", startSignal, 1);
        rst = 1'b1;
        #1;
        chk("rs_start_gated", startSignal, 0);
        tick();
        rst = 1'b0;
        chk("rs_idle", busy, 0);
        chk("rs_bus32", bus32, 0);

`ifdef VAM_TIMEOUT_EN
        // Watchdog expiry after TIMEOUT WAIT cycles.
        push_now(16'h0A0A, 16'h0B0B);
        wait_start("to");
        tick();
        repeat (TB_TIMEOUT - 2) tick();
        chk("to_not_yet_err", timeout_err, 0);
        tick();
        chk("to_last_cycle_valid", out_valid, 0);
        tick();
        chk("to_err", timeout_err, 1);
        chk("to_valid", out_valid, 1);
        chk("to_rslt", out_rslt, 32'hFFFF_FFFF);
        release_out();
        chk("to_sticky", timeout_err, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("to_cleared", timeout_err, 0);
        // readyPulse on the expiry cycle wins.
        push_now(16'h0C0C, 16'h0D0D);
        wait_start("tr");
        tick();
        repeat (TB_TIMEOUT - 1) tick();
        readyPulse = 1'b1; rsltW = 32'h0000_0042;
        tick();
        readyPulse = 1'b0;
        chk("tr_valid", out_valid, 1);
        chk("tr_rslt", out_rslt, 32'h0000_0042);
        chk("tr_no_err", timeout_err, 0);
        release_out();
`else
        // Without the watchdog WAIT persists indefinitely.
        push_now(16'h0A0A, 16'h0B0B);
        wait_start("nw");
        tick();
        repeat (80) tick();
        chk("nw_still_busy", busy, 1);
        chk("nw_no_valid", out_valid, 0);
        chk("nw_no_err", timeout_err, 0);
        readyPulse = 1'b1; rsltW = 32'h0000_0042;
        tick();
        readyPulse = 1'b0;
        chk("nw_rslt", out_rslt, 32'h0000_0042);
        release_out();
`endif
        chk("final_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
